dma_arbiter: RTL and testbench

Round-robin arbiter sharing the single CCX DMA TileLink port (128-bit, TL-UH: A and D channels only) among `NumHosts` DMA-capable IO masters, e.g. SDHCI and future engines.
- Locks the grant for the full duration of multi-beat A-channel bursts.
- Tags each request's source ID with the host index.
- Routes D-channel responses back by that tag.
- B/C/E channels are not handled; the top level ties them off (B ready low, C/E valid low) as today.

---
 rtl/dma_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dma_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one TL-UH DMA port among several IO masters.
// Locks the grant for multi-beat A bursts and routes D beats back by source tag.
module dma_arbiter #(
  parameter int NumHosts          = 2,
  parameter int DataWidth         = 128,
  parameter int AddrWidth         = 38,
  parameter int HostSourceWidth   = 2,
  parameter int DeviceSourceWidth = 3,
  parameter int SinkWidth         = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,

  input  logic [NumHosts-1:0]                       host_a_valid_i,
  output logic [NumHosts-1:0]                       host_a_ready_o,
  input  logic [NumHosts-1:0][2:0]                  host_a_opcode_i,
  input  logic [NumHosts-1:0][2:0]                  host_a_param_i,
  input  logic [NumHosts-1:0][2:0]                  host_a_size_i,
  input  logic [NumHosts-1:0][HostSourceWidth-1:0]  host_a_source_i,
  input  logic [NumHosts-1:0][AddrWidth-1:0]        host_a_address_i,
  input  logic [NumHosts-1:0][DataWidth/8-1:0]      host_a_mask_i,
  input  logic [NumHosts-1:0][DataWidth-1:0]        host_a_data_i,
  input  logic [NumHosts-1:0]                       host_a_corrupt_i,

  output logic [NumHosts-1:0]                       host_d_valid_o,
  input  logic [NumHosts-1:0]                       host_d_ready_i,
  output logic [2:0]                                host_d_opcode_o,
  output logic [1:0]                                host_d_param_o,
  output logic [2:0]                                host_d_size_o,
  output logic [HostSourceWidth-1:0]                host_d_source_o,
  output logic [SinkWidth-1:0]                      host_d_sink_o,
  output logic                                      host_d_denied_o,
  output logic                                      host_d_corrupt_o,
  output logic [DataWidth-1:0]                      host_d_data_o,

  output logic                                      dev_a_valid_o,
  input  logic                                      dev_a_ready_i,
  output logic [2:0]                                dev_a_opcode_o,
  output logic [2:0]                                dev_a_param_o,
  output logic [2:0]                                dev_a_size_o,
  output logic [DeviceSourceWidth-1:0]              dev_a_source_o,
  output logic [AddrWidth-1:0]                      dev_a_address_o,
  output logic [DataWidth/8-1:0]                    dev_a_mask_o,
  output logic [DataWidth-1:0]                      dev_a_data_o,
  output logic                                      dev_a_corrupt_o,

  input  logic                                      dev_d_valid_i,
  output logic                                      dev_d_ready_o,
  input  logic [2:0]                                dev_d_opcode_i,
  input  logic [1:0]                                dev_d_param_i,
  input  logic [2:0]                                dev_d_size_i,
  input  logic [DeviceSourceWidth-1:0]              dev_d_source_i,
  input  logic [SinkWidth-1:0]                      dev_d_sink_i,
  input  logic                                      dev_d_denied_i,
  input  logic                                      dev_d_corrupt_i,
  input  logic [DataWidth-1:0]                      dev_d_data_i
);

  localparam int IdxW    = (NumHosts > 2) ? $clog2(NumHosts) : 1;
  localparam int LogBeat = $clog2(DataWidth / 8);
  localparam logic [2:0]    LogBeatW  = 3'(LogBeat);
  localparam logic [IdxW:0] NumHostsW = (IdxW + 1)'(NumHosts);

  typedef logic [IdxW-1:0] idx_t;

  logic       locked;
  idx_t       owner;
  idx_t       rr_ptr;
  logic [7:0] beats_left;

  idx_t       grant;
  idx_t       sel;
  idx_t       sel_next;
  logic [7:0] beats;
  logic       a_fire;
  logic       last_beat;
  logic       found;
  int         j;

  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NumHosts; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NumHosts) j = j - NumHosts;
      if (!found && host_a_valid_i[j]) begin
        found = 1'b1;
        grant = idx_t'(j);
      end
    end
  end

  assign sel      = locked ? owner : grant;
  assign sel_next = (sel == idx_t'(NumHosts - 1)) ? '0 : sel + 1'b1;

  assign dev_a_valid_o   = host_a_valid_i[sel];
  assign dev_a_opcode_o  = host_a_opcode_i[sel];
  assign dev_a_param_o   = host_a_param_i[sel];
  assign dev_a_size_o    = host_a_size_i[sel];
  assign dev_a_source_o  = {sel, host_a_source_i[sel]};
  assign dev_a_address_o = host_a_address_i[sel];
  assign dev_a_mask_o    = host_a_mask_i[sel];
  assign dev_a_data_o    = host_a_data_i[sel];
  assign dev_a_corrupt_o = host_a_corrupt_i[sel];

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      host_a_ready_o[i] = dev_a_ready_i && (sel == idx_t'(i));
    end
  end

  // Only data-carrying opcodes (Put/Atomic) span more than one beat.
  always_comb begin
    beats = 8'd1;
    if (dev_a_opcode_o <= 3'd3 && dev_a_size_o > LogBeatW) begin
      beats = 8'd1 << (dev_a_size_o - LogBeatW);
    end
  end

  assign a_fire    = dev_a_valid_o && dev_a_ready_i;
  assign last_beat = locked ? (beats_left == 8'd1) : (beats == 8'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked     <= 1'b0;
      owner      <= '0;
      rr_ptr     <= '0;
      beats_left <= '0;
    end else if (a_fire) begin
      if (!locked) begin
        if (!last_beat) begin
          locked     <= 1'b1;
          owner      <= sel;
          beats_left <= beats - 8'd1;
        end
      end else begin
        beats_left <= beats_left - 8'd1;
        if (last_beat) locked <= 1'b0;
      end
      if (last_beat) rr_ptr <= sel_next;
    end
  end

  idx_t d_idx;
  logic d_idx_ok;

  assign d_idx    = dev_d_source_i[DeviceSourceWidth-1 -: IdxW];
  assign d_idx_ok = {1'b0, d_idx} < NumHostsW;

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      host_d_valid_o[i] = dev_d_valid_i && d_idx_ok && (d_idx == idx_t'(i));
    end
  end

  // Beats tagged for a non-existent host are sunk so the device never stalls.
  assign dev_d_ready_o = d_idx_ok ? host_d_ready_i[d_idx] : 1'b1;

  assign host_d_opcode_o  = dev_d_opcode_i;
  assign host_d_param_o   = dev_d_param_i;
  assign host_d_size_o    = dev_d_size_i;
  assign host_d_source_o  = dev_d_source_i[HostSourceWidth-1:0];
  assign host_d_sink_o    = dev_d_sink_i;
  assign host_d_denied_o  = dev_d_denied_i;
  assign host_d_corrupt_o = dev_d_corrupt_i;
  assign host_d_data_o    = dev_d_data_i;

endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboard bench for dma_arbiter: host models feed A beats, the
// expected grant order is queued up front and checked as beats fire.
module tb_dma_arbiter;

  localparam int NH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NH-1:0]         a_vld;
  logic [NH-1:0]         a_rdy;
  logic [NH-1:0][2:0]    a_op;
  logic [NH-1:0][2:0]    a_pr;
  logic [NH-1:0][2:0]    a_sz;
  logic [NH-1:0][1:0]    a_src;
  logic [NH-1:0][37:0]   a_addr;
  logic [NH-1:0][15:0]   a_mask;
  logic [NH-1:0][127:0]  a_data;
  logic [NH-1:0]         a_cor;

  logic [NH-1:0]  hd_vld;
  logic [NH-1:0]  hd_rdy;
  logic [2:0]     hd_op;
  logic [1:0]     hd_pr;
  logic [2:0]     hd_sz;
  logic [1:0]     hd_src;
  logic [3:0]     hd_sink;
  logic           hd_den;
  logic           hd_cor;
  logic [127:0]   hd_data;

  logic           da_vld;
  logic           da_rdy;
  logic [2:0]     da_op;
  logic [2:0]     da_pr;
  logic [2:0]     da_sz;
  logic [2:0]     da_src;
  logic [37:0]    da_addr;
  logic [15:0]    da_mask;
  logic [127:0]   da_data;
  logic           da_cor;

  logic           dd_vld;
  logic           dd_rdy;
  logic [2:0]     dd_op;
  logic [1:0]     dd_pr;
  logic [2:0]     dd_sz;
  logic [2:0]     dd_src;
  logic [3:0]     dd_sink;
  logic           dd_den;
  logic           dd_cor;
  logic [127:0]   dd_data;

  dma_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .host_a_valid_i   (a_vld),
    .host_a_ready_o   (a_rdy),
    .host_a_opcode_i  (a_op),
    .host_a_param_i   (a_pr),
    .host_a_size_i    (a_sz),
    .host_a_source_i  (a_src),
    .host_a_address_i (a_addr),
    .host_a_mask_i    (a_mask),
    .host_a_data_i    (a_data),
    .host_a_corrupt_i (a_cor),
    .host_d_valid_o   (hd_vld),
    .host_d_ready_i   (hd_rdy),
    .host_d_opcode_o  (hd_op),
    .host_d_param_o   (hd_pr),
    .host_d_size_o    (hd_sz),
    .host_d_source_o  (hd_src),
    .host_d_sink_o    (hd_sink),
    .host_d_denied_o  (hd_den),
    .host_d_corrupt_o (hd_cor),
    .host_d_data_o    (hd_data),
    .dev_a_valid_o    (da_vld),
    .dev_a_ready_i    (da_rdy),
    .dev_a_opcode_o   (da_op),
    .dev_a_param_o    (da_pr),
    .dev_a_size_o     (da_sz),
    .dev_a_source_o   (da_src),
    .dev_a_address_o  (da_addr),
    .dev_a_mask_o     (da_mask),
    .dev_a_data_o     (da_data),
    .dev_a_corrupt_o  (da_cor),
    .dev_d_valid_i    (dd_vld),
    .dev_d_ready_o    (dd_rdy),
    .dev_d_opcode_i   (dd_op),
    .dev_d_param_i    (dd_pr),
    .dev_d_size_i     (dd_sz),
    .dev_d_source_i   (dd_src),
    .dev_d_sink_i     (dd_sink),
    .dev_d_denied_i   (dd_den),
    .dev_d_corrupt_i  (dd_cor),
    .dev_d_data_i     (dd_data)
  );

  typedef struct {
    logic [2:0]   op;
    logic [2:0]   sz;
    logic [1:0]   src;
    logic [37:0]  addr;
    logic [127:0] data;
  } beat_t;

  typedef struct {
    int    host;
    beat_t b;
  } exp_t;

  beat_t hq[NH][$];
  beat_t sh[NH][$];
  exp_t  sb[$];

  int n_vec = 0;
  int n_err = 0;
  int dcnt  = 0;
  logic [NH-1:0] fired;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NH; i++) begin
      a_pr[i]   = 3'd0;
      a_mask[i] = 16'hffff;
      a_cor[i]  = 1'b0;
      if (hq[i].size() > 0) begin
        a_vld[i]  = 1'b1;
        a_op[i]   = hq[i][0].op;
        a_sz[i]   = hq[i][0].sz;
        a_src[i]  = hq[i][0].src;
        a_addr[i] = hq[i][0].addr;
        a_data[i] = hq[i][0].data;
      end else begin
        a_vld[i]  = 1'b0;
        a_op[i]   = 3'd0;
        a_sz[i]   = 3'd0;
        a_src[i]  = 2'd0;
        a_addr[i] = '0;
        a_data[i] = '0;
      end
    end
  endtask

  task automatic push_msg(input int h, input logic [2:0] op,
                          input logic [2:0] sz, input logic [1:0] src,
                          input int nb);
    beat_t b;
    b.op   = op;
    b.sz   = sz;
    b.src  = src;
    b.addr = {6'd0, 32'($urandom)};
    for (int k = 0; k < nb; k++) begin
      dcnt++;
      b.data = {4{32'(dcnt)}};
      hq[h].push_back(b);
      sh[h].push_back(b);
    end
  endtask

  task automatic expect_from(input int h, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.host = h;
      e.b    = sh[h].pop_front();
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    fired = a_vld & a_rdy;
    if (!rst && (|a_vld)) begin
      if (sb.size() == 0) begin
        chk("unexpected_a", 128'(da_vld), 128'(0));
      end else begin
        e = sb[0];
        chk("a_valid", 128'(da_vld), 128'(1));
        chk("a_source", 128'(da_src), 128'({e.host[0], e.b.src}));
        chk("a_addr", 128'(da_addr), 128'(e.b.addr));
        chk("a_data", da_data, e.b.data);
        chk("a_hdr", 128'({da_op, da_sz}), 128'({e.b.op, e.b.sz}));
        chk("a_ready", 128'(a_rdy),
            da_rdy ? 128'(2'b01 << e.host) : 128'(0));
        if (da_vld && da_rdy) void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NH; i++) begin
      if (fired[i] && hq[i].size() > 0) void'(hq[i].pop_front());
    end
    drive();
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 60 && sb.size() > 0; c++) tick();
    chk(tag, 128'(sb.size()), 128'(0));
  endtask

  initial begin
    logic [5:0] pat;
    da_rdy  = 1'b1;
    dd_vld  = 1'b0;
    dd_op   = 3'd0;
    dd_pr   = 2'd0;
    dd_sz   = 3'd0;
    dd_src  = 3'd0;
    dd_sink = 4'd0;
    dd_den  = 1'b0;
    dd_cor  = 1'b0;
    dd_data = '0;
    hd_rdy  = 2'b11;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_valid", 128'(da_vld), 128'(0));
    chk("rst_d_valid", 128'(hd_vld), 128'(0));
    @(posedge clk);
    #1;

    // Alternating single Gets; host0 wins first out of reset.
    for (int k = 0; k < 3; k++) push_msg(0, 3'd4, 3'd4, 2'b01, 1);
    for (int k = 0; k < 2; k++) push_msg(1, 3'd4, 3'd3, 2'b10, 1);
    expect_from(0, 1); expect_from(1, 1);
    expect_from(0, 1); expect_from(1, 1);
    expect_from(0, 1);
    drive();
    drain("alt_drain");

    // Burst lock: host1 Get arrives mid-burst and must wait.
    push_msg(0, 3'd0, 3'd6, 2'b01, 4);
    expect_from(0, 4);
    drive();
    tick();
    tick();
    push_msg(1, 3'd4, 3'd3, 2'b11, 1);
    expect_from(1, 1);
    drive();
    drain("lock_drain");
    push_msg(0, 3'd4, 3'd2, 2'b00, 1);
    push_msg(1, 3'd4, 3'd2, 2'b01, 1);
    expect_from(0, 1); expect_from(1, 1);
    drive();
    drain("rr_after_lock");

    // Back-pressure in a host1 burst with host0 waiting.
    push_msg(1, 3'd0, 3'd6, 2'b10, 4);
    expect_from(1, 4);
    drive();
    pat = 6'b111001;
    for (int p = 0; p < 6; p++) begin
      da_rdy = pat[p];
      if (p == 1) begin
        push_msg(0, 3'd4, 3'd4, 2'b11, 1);
        expect_from(0, 1);
        drive();
      end
      tick();
    end
    chk("bp_fires", 128'(sb.size()), 128'(1));
    da_rdy = 1'b1;
    drain("bp_drain");

    // D routing by source tag, including stall from the owning host.
    dd_vld  = 1'b1;
    dd_op   = 3'd1;
    dd_sz   = 3'd5;
    dd_src  = 3'b110;
    dd_sink = 4'h9;
    hd_rdy  = 2'b10;
    for (int k = 0; k < 2; k++) begin
      dd_data = {4{32'hd0d0_0000 + 32'(k)}};
      @(negedge clk);
      chk("d_valid", 128'(hd_vld), 128'(2'b10));
      chk("d_source", 128'(hd_src), 128'(2'b10));
      chk("d_ready", 128'(dd_rdy), 128'(1));
      chk("d_data", hd_data, {4{32'hd0d0_0000 + 32'(k)}});
      chk("d_hdr", 128'({hd_op, hd_sz, hd_sink}), 128'({3'd1, 3'd5, 4'h9}));
    end
    hd_rdy = 2'b01;
    @(negedge clk);
    chk("d_stall", 128'(dd_rdy), 128'(0));
    dd_src = 3'b001;
    @(negedge clk);
    chk("d_valid0", 128'(hd_vld), 128'(2'b01));
    chk("d_ready0", 128'(dd_rdy), 128'(1));
    dd_vld = 1'b0;
    hd_rdy = 2'b11;
    @(posedge clk);
    #1;

    // Reset after two beats of a host0 burst.
    push_msg(0, 3'd0, 3'd6, 2'b01, 4);
    expect_from(0, 2);
    drive();
    tick();
    tick();
    hq[0].delete();
    sh[0].delete();
    drive();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_msg(0, 3'd4, 3'd4, 2'b10, 1);
    push_msg(1, 3'd4, 3'd4, 2'b01, 1);
    expect_from(0, 1); expect_from(1, 1);
    drive();
    tick();
    chk("post_rst_grant", 128'(sb.size()), 128'(1));
    drain("rst_drain");

    // Sub-beat PutPartial and size-6 Get stay single beat.
    push_msg(0, 3'd1, 3'd2, 2'b01, 1);
    push_msg(0, 3'd4, 3'd6, 2'b10, 1);
    push_msg(1, 3'd0, 3'd5, 2'b11, 2);
    expect_from(0, 1); expect_from(1, 2); expect_from(0, 1);
    drive();
    drain("subbeat_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end

endmodule
